// File: rtl/t1s_tick_gen_if.sv
// Tick output bundle: the tick generator drives s, consumers (control/state selection) read it.
interface t1s_tick_gen_if;
    logic s;

    modport master (output s);
    modport slave  (input  s);
endinterface

// File: rtl/t1s_tick_gen.sv
// Free-running timebase: divides clk by CLK_FREQ_HZ and emits a registered tick
// (1-cycle strobe or half-rate square wave) on tick.s.
module t1s_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter bit          PULSE_MODE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    t1s_tick_gen_if.master        tick
);

    // Clamp keeps the width legal so an illegal N reports the intended error.
    localparam int unsigned CNT_W = (CLK_FREQ_HZ < 2) ? 1 : $clog2(CLK_FREQ_HZ);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ_HZ - 1);

    if (CLK_FREQ_HZ < 2) begin : g_bad_freq
        $error("t1s_tick_gen: CLK_FREQ_HZ must be >= 2");
    end

    logic [CNT_W-1:0] cnt;
    logic             s_q;
    logic             wrap;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            s_q <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            if (PULSE_MODE)
                s_q <= wrap;
            else if (wrap)
                s_q <= ~s_q;
        end
    end

    assign tick.s = s_q;

endmodule

// File: tb/tb_t1s_tick_gen.sv
// Randomized reset/run bench for t1s_tick_gen over several N and both output modes.
module tb_t1s_tick_gen;

    localparam int NDUT = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    t1s_tick_gen_if if_p10 ();
    t1s_tick_gen_if if_t10 ();
    t1s_tick_gen_if if_p2  ();
    t1s_tick_gen_if if_t2  ();
    t1s_tick_gen_if if_p7  ();
    t1s_tick_gen_if if_t7  ();
    t1s_tick_gen_if if_p8  ();
    t1s_tick_gen_if if_def ();

    t1s_tick_gen #(.CLK_FREQ_HZ(10), .PULSE_MODE(1'b1)) u_p10 (.clk(clk), .rst_n(rst_n), .tick(if_p10));
    t1s_tick_gen #(.CLK_FREQ_HZ(10), .PULSE_MODE(1'b0)) u_t10 (.clk(clk), .rst_n(rst_n), .tick(if_t10));
    t1s_tick_gen #(.CLK_FREQ_HZ(2),  .PULSE_MODE(1'b1)) u_p2  (.clk(clk), .rst_n(rst_n), .tick(if_p2));
    t1s_tick_gen #(.CLK_FREQ_HZ(2),  .PULSE_MODE(1'b0)) u_t2  (.clk(clk), .rst_n(rst_n), .tick(if_t2));
    t1s_tick_gen #(.CLK_FREQ_HZ(7),  .PULSE_MODE(1'b1)) u_p7  (.clk(clk), .rst_n(rst_n), .tick(if_p7));
    t1s_tick_gen #(.CLK_FREQ_HZ(7),  .PULSE_MODE(1'b0)) u_t7  (.clk(clk), .rst_n(rst_n), .tick(if_t7));
    t1s_tick_gen #(.CLK_FREQ_HZ(8),  .PULSE_MODE(1'b1)) u_p8  (.clk(clk), .rst_n(rst_n), .tick(if_p8));
    t1s_tick_gen u_def (.clk(clk), .rst_n(rst_n), .tick(if_def));

    logic [NDUT-1:0] s_vec;
    assign s_vec = {if_def.s, if_p8.s, if_t7.s, if_p7.s, if_t2.s, if_p2.s, if_t10.s, if_p10.s};

    int    ns    [NDUT] = '{10, 10, 2, 2, 7, 7, 8, 50_000_000};
    bit    pm    [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    string names [NDUT] = '{"p10", "t10", "p2", "t2", "p7", "t7", "p8", "def"};

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Rising clk edges seen since the last reset release; the whole model hangs off this.
    int k = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k = 0;
        else        k = k + 1;
    end

    function automatic logic exp_s(int n, bit pulse, int edges);
        if (pulse) return (edges > 0) && (edges % n == 0);
        return ((edges / n) % 2) == 1;
    endfunction

    task automatic check(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NDUT; i++)
                check($sformatf("%s k=%0d", names[i], k), s_vec[i], exp_s(ns[i], pm[i], k));
        end
    end

    task automatic assert_reset_midcycle();
        @(negedge clk);
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("%s async_clear", names[i]), s_vec[i], 1'b0);
    endtask

    task automatic release_reset_midcycle(int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #($urandom_range(1, 4));
        rst_n = 1'b1;
    endtask

    logic [0:11] pin_p10 = 12'b000000000100;
    logic [0:11] pin_p2  = 12'b010101010101;
    logic [0:23] pin_t10 = 24'b000000000111111111100000;
    logic [0:13] pin_p7  = 14'b00000010000001;

    initial begin
        int e;
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        checking = 1'b1;
        release_reset_midcycle(0);

        // Literal pins: first ticks after release, indexed by edge number.
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i <= 12) begin
                check($sformatf("pin_p10 e=%0d", i), if_p10.s, pin_p10[i-1]);
                check($sformatf("pin_p2 e=%0d", i),  if_p2.s,  pin_p2[i-1]);
            end
            if (i <= 14) check($sformatf("pin_p7 e=%0d", i), if_p7.s, pin_p7[i-1]);
            check($sformatf("pin_t10 e=%0d", i), if_t10.s, pin_t10[i-1]);
        end

        // Reset mid-period with the N=10 counter at 6, held for 3 cycles.
        while (k != 26) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("%s cnt6_clear", names[i]), s_vec[i], 1'b0);
        release_reset_midcycle(3);
        e = 0;
        seen = 1'b0;
        while (!seen && e < 20) begin
            @(negedge clk);
            e++;
            if (if_p10.s) seen = 1'b1;
        end
        check("p10 first_tick_after_rerelease", seen && (e == 10), 1'b1);

        // Long unbroken run so the N=7 interval repeats many times.
        repeat (100) @(posedge clk);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(1, 60)) @(posedge clk);
            if ($urandom_range(0, 2) != 0) begin
                assert_reset_midcycle();
                release_reset_midcycle($urandom_range(0, 4));
            end
        end

        repeat (25) @(posedge clk);
        @(negedge clk);
        checking = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
